// File: rtl/instruction_sender.sv
// rtl/instruction_sender.sv - bit-serial servo instruction transmitter; optional wait timeouts via SENDER_TIMEOUT_EN
module instruction_sender #(
  parameter int INSTR_W        = 10,
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               waiting,
  output logic               mbedCommand,
  output logic               confirm,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_B = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int MAX_C = (MAX_B > TIMEOUT_CYCLES) ? MAX_B : TIMEOUT_CYCLES;
  localparam int PH_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int CNT_W = $clog2(INSTR_W + 1);

  localparam logic [PH_W-1:0]  SETUP_LOAD  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0]  STROBE_LOAD = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GAP_LOAD    = PH_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0]  WAIT_LOAD   = PH_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BITS_LOAD   = CNT_W'(INSTR_W);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, WAIT_RX, SETUP, STROBE, GAP, WAIT_ACK} state_t;

  state_t             state;
  logic [INSTR_W-1:0] word_q;
  logic [INSTR_W-1:0] shift_q;
  logic [INSTR_W-1:0] shift_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [PH_W-1:0]    ph_cnt;
  logic               ph_zero;
  logic               clr_seen;
  logic               clr_now;
  logic               restart;

  // Next shift value and detection of a receiver clear before the final bit
  always_comb begin
    shift_nxt = shift_q << 1;
    ph_zero   = (ph_cnt == '0);
    clr_now   = ((state == SETUP) || (state == STROBE) || (state == GAP)) &&
                !waiting && (bit_cnt > LAST_BIT);
    restart   = clr_seen || clr_now;
  end

  // Transfer sequencer; every output is registered so confirm cannot glitch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      word_q      <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      ph_cnt      <= '0;
      clr_seen    <= 1'b0;
      instr_ready <= 1'b1;
      mbedCommand <= 1'b0;
      confirm     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      if (clr_now) clr_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            word_q      <= instr_in;
            shift_q     <= instr_in;
            bit_cnt     <= BITS_LOAD;
            ph_cnt      <= WAIT_LOAD;
            clr_seen    <= 1'b0;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (waiting) begin
            mbedCommand <= shift_q[INSTR_W-1];
            ph_cnt      <= SETUP_LOAD;
            state       <= SETUP;
`ifdef SENDER_TIMEOUT_EN
          end else if (ph_zero) begin
            timeout_err <= 1'b1;
            mbedCommand <= 1'b0;
            confirm     <= 1'b0;
            word_q      <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
`endif
          end
        end
        SETUP: begin
          if (ph_zero) begin
            confirm <= 1'b1;
            ph_cnt  <= STROBE_LOAD;
            state   <= STROBE;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        STROBE: begin
          if (ph_zero) begin
            confirm <= 1'b0;
            ph_cnt  <= GAP_LOAD;
            state   <= GAP;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        GAP: begin
          if (!ph_zero) begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end else if (restart) begin
            // Receiver was cleared mid-word: resend the kept word from its MSB
            shift_q     <= word_q;
            bit_cnt     <= BITS_LOAD;
            clr_seen    <= 1'b0;
            mbedCommand <= 1'b0;
            ph_cnt      <= WAIT_LOAD;
            state       <= WAIT_RX;
          end else if (bit_cnt == LAST_BIT) begin
            shift_q     <= shift_nxt;
            bit_cnt     <= '0;
            mbedCommand <= 1'b0;
            ph_cnt      <= WAIT_LOAD;
            state       <= WAIT_ACK;
          end else begin
            shift_q     <= shift_nxt;
            bit_cnt     <= bit_cnt - CNT_W'(1);
            mbedCommand <= shift_nxt[INSTR_W-1];
            ph_cnt      <= SETUP_LOAD;
            state       <= SETUP;
          end
        end
        WAIT_ACK: begin
          if (done) begin
            // done has had its cycle; reopen for the next word
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (!waiting) begin
            done <= 1'b1;
`ifdef SENDER_TIMEOUT_EN
          end else if (ph_zero) begin
            timeout_err <= 1'b1;
            mbedCommand <= 1'b0;
            confirm     <= 1'b0;
            word_q      <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
`endif
          end
        end
        default: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          confirm     <= 1'b0;
          mbedCommand <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sender.sv
// tb/tb_instruction_sender.sv - directed vector bench for instruction_sender
`timescale 1ns/1ps
module tb_instruction_sender;

  localparam int W      = 10;
  localparam int SETUP  = 1;
  localparam int STROBE = 4;
  localparam int GAP    = 4;
  localparam int TO     = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] instr_in = '0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic         waiting = 1'b0;
  logic         mbedCommand;
  logic         confirm;
  logic         busy;
  logic         done;
  logic         timeout_err;

  always #5 clk = ~clk;

  instruction_sender #(
    .INSTR_W(W), .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .waiting(waiting), .mbedCommand(mbedCommand),
    .confirm(confirm), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: strobe counts, pulse widths, captured bits, event cycles
  int          stb_cnt = 0, hi_bad = 0, lo_bad = 0, mbed_bad = 0, done_cnt = 0, to_cnt = 0;
  int          hi_len = 0, lo_len = 0, last_fall = 0, done_cyc = 0, to_cyc = 0;
  bit          lo_valid = 1'b0;
  logic        conf_q = 1'b0, mbed_q = 1'b0;
  logic [31:0] cap_all = '0;
  int          rise_log[$];

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (timeout_err) begin to_cnt++; to_cyc = cyc; end
    if (confirm && !conf_q) begin
      stb_cnt++;
      cap_all = {cap_all[30:0], mbedCommand};
      rise_log.push_back(cyc);
      if (lo_valid && lo_len != GAP + SETUP) lo_bad++;
      hi_len = 1;
    end else if (confirm) begin
      hi_len++;
      if (mbedCommand !== mbed_q) mbed_bad++;
    end else if (conf_q) begin
      if (hi_len != STROBE) hi_bad++;
      last_fall = cyc;
      lo_len = 1;
      lo_valid = 1'b1;
    end else begin
      lo_len++;
    end
    if (!busy) lo_valid = 1'b0;
    conf_q = confirm;
    mbed_q = mbedCommand;
  end

  typedef struct {
    logic [W-1:0] word;
    int           ack_gap;
    logic [W-1:0] exp_bits;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] w, input bit keep_valid, output int acc);
    int n;
    n = 0;
    instr_in = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 500) begin tick(); n++; end
    check("accept_ready", instr_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep_valid) instr_valid = 1'b0;
  endtask

  task automatic finish(input int base, input int nstb, input int gap, input string tag,
                        output int rdy_hi);
    int  n;
    int  drop_at;
    bit  dropped;
    n = 0; dropped = 1'b0; drop_at = -10; rdy_hi = 0;
    while (n < 600) begin
      tick(); n++;
      if (instr_ready) rdy_hi++;
      if (done) break;
      if (!dropped && (stb_cnt - base == nstb) && !confirm && cyc == last_fall + GAP + gap) begin
        waiting = 1'b0; dropped = 1'b1; drop_at = cyc;
      end
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_done_lat"}, done_cyc, drop_at + 1);
    tick();
    check({tag, "_ready_after_done"}, instr_ready, 1);
    waiting = 1'b1;
  endtask

  int base, hb, lb, mb, dc, tc, rb, acc, acc2, rdy, n;

  initial begin
    vecs[0] = '{10'b1010110011, 5,  10'b1010110011};
    vecs[1] = '{10'b1111111111, 5,  10'b1111111111};
    vecs[2] = '{10'b0000000000, 3,  10'b0000000000};
    vecs[3] = '{10'b1000000001, 15, 10'b1000000001};
    vecs[4] = '{10'b0110100101, 1,  10'b0110100101};

    // reset state
    repeat (3) tick();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_confirm", confirm, 0);
    check("rst_mbed", mbedCommand, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_err, 0);
    reset = 1'b1;
    waiting = 1'b1;
    tick();
    check("post_rst_ready", instr_ready, 1);

    // table of basic sends
    for (int i = 0; i < 5; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      base = stb_cnt; hb = hi_bad; lb = lo_bad; mb = mbed_bad;
      dc = done_cnt; tc = to_cnt; rb = rise_log.size();
      accept(vecs[i].word, 1'b0, acc);
      finish(base, 10, vecs[i].ack_gap, t, rdy);
      check({t, "_strobes"}, stb_cnt - base, 10);
      check({t, "_bits"}, cap_all[W-1:0], vecs[i].exp_bits);
      check({t, "_first_rise"}, (rise_log.size() > rb) ? rise_log[rb] : -1, acc + 1 + SETUP);
      check({t, "_hi_width"}, hi_bad - hb, 0);
      check({t, "_lo_width"}, lo_bad - lb, 0);
      check({t, "_mbed_stable"}, mbed_bad - mb, 0);
      check({t, "_done_count"}, done_cnt - dc, 1);
      check({t, "_no_timeout"}, to_cnt - tc, 0);
      check({t, "_ready_low"}, rdy, 0);
    end

`ifndef SENDER_TIMEOUT_EN
    // receiver not ready for 50 cycles
    waiting = 1'b0;
    base = stb_cnt; tc = to_cnt; rb = rise_log.size();
    accept(10'b0011100110, 1'b0, acc);
    repeat (50) tick();
    check("nr_no_strobe", stb_cnt - base, 0);
    check("nr_confirm_low", confirm, 0);
    check("nr_busy", busy, 1);
    check("nr_no_timeout", to_cnt - tc, 0);
    waiting = 1'b1;
    acc2 = cyc;
    finish(base, 10, 5, "nr", rdy);
    check("nr_first_rise", (rise_log.size() > rb) ? rise_log[rb] : -1, acc2 + 2);
    check("nr_bits", cap_all[W-1:0], 10'b0011100110);
`else
    // receiver never acknowledges: WAIT_ACK timeout
    base = stb_cnt; dc = done_cnt; tc = to_cnt;
    accept(10'b1010110011, 1'b0, acc);
    n = 0;
    while (n < 300 && !timeout_err && !done) begin tick(); n++; end
    check("ta_timeout_seen", timeout_err, 1);
    check("ta_timeout_lat", to_cyc, last_fall + GAP + TO);
    check("ta_ready", instr_ready, 1);
    check("ta_mbed", mbedCommand, 0);
    check("ta_confirm", confirm, 0);
    tick();
    check("ta_pulse_once", to_cnt - tc, 1);
    check("ta_no_done", done_cnt - dc, 0);
    check("ta_idle", busy, 0);

    // receiver never ready: WAIT_RX timeout
    waiting = 1'b0;
    base = stb_cnt; tc = to_cnt;
    accept(10'b0101010101, 1'b0, acc);
    n = 0;
    while (n < 100 && !timeout_err) begin tick(); n++; end
    check("tr_timeout_seen", timeout_err, 1);
    check("tr_timeout_lat", to_cyc, acc + TO);
    check("tr_no_strobe", stb_cnt - base, 0);
    tick();
    check("tr_idle", busy, 0);
    waiting = 1'b1;
`endif

    // mid-word clear during bit 6 strobe
    base = stb_cnt; dc = done_cnt;
    accept(10'b1100101101, 1'b0, acc);
    n = 0;
    while (n < 200 && (stb_cnt - base) < 4) begin tick(); n++; end
    check("mid_in_strobe", confirm, 1);
    waiting = 1'b0;
    repeat (10) tick();
    waiting = 1'b1;
    finish(base, 14, 5, "mid", rdy);
    check("mid_strobes", stb_cnt - base, 14);
    check("mid_bits", cap_all[13:0], 14'b11001100101101);
    check("mid_done_count", done_cnt - dc, 1);

    // back-pressure: second word held valid during the first transfer
    base = stb_cnt;
    accept(10'b0110011010, 1'b1, acc);
    instr_in = 10'b1001110001;
    finish(base, 10, 5, "bp_a", rdy);
    check("bp_ready_low", rdy, 0);
    check("bp_a_bits", cap_all[W-1:0], 10'b0110011010);
    base = stb_cnt;
    accept(10'b1001110001, 1'b0, acc2);
    check("bp_b_accept_cyc", acc2, done_cyc + 2);
    finish(base, 10, 5, "bp_b", rdy);
    check("bp_b_strobes", stb_cnt - base, 10);
    check("bp_b_bits", cap_all[W-1:0], 10'b1001110001);

    // reset asserted in the middle of a strobe
    base = stb_cnt;
    accept(10'b1110001110, 1'b0, acc);
    n = 0;
    while (n < 200 && (stb_cnt - base) < 3) begin tick(); n++; end
    check("rm_in_strobe", confirm, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rm_confirm_async", confirm, 0);
    check("rm_ready_async", instr_ready, 1);
    check("rm_busy_async", busy, 0);
    repeat (2) tick();
    reset = 1'b1;
    base = stb_cnt;
    tick();
    check("rm_ready", instr_ready, 1);
    check("rm_mbed", mbedCommand, 0);
    check("rm_done", done, 0);
    check("rm_timeout", timeout_err, 0);
    repeat (20) tick();
    check("rm_word_dropped", stb_cnt - base, 0);
    check("rm_still_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
